// File: rtl/uart_rx_monitor.sv
// UART receive monitor: 8N1 (8E1 with UART_RX_MON_PARITY_EN) deserializer feeding a small byte FIFO, with sticky error flags.
// Latency: byte is visible on data_o/valid_o one cycle after the mid-stop-bit sample (2-cycle input synchronizer ahead of that).
// Backpressure: valid_o/ready_i pop; a byte arriving while the FIFO is full is dropped and sets overrun_o.
module uart_rx_monitor #(
  parameter int BIT_CYCLES = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_i,
  input  logic        rx_en_i,
  input  logic        clear_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        frame_err_o,
  output logic        overrun_o,
  output logic [15:0] char_cnt_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [15:0] HALF_BIT = 16'(BIT_CYCLES / 2 - 1);
  localparam logic [15:0] FULL_BIT = 16'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_MON_PARITY_EN
    S_PAR,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state;
  logic            rx_s1, rx_s2, rx_prev;
  logic [15:0]     bit_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            push_vld;
  logic [7:0]      push_dat;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full, pop, push_ok, push_drop, stop_ok;

`ifdef UART_RX_MON_PARITY_EN
  logic            par_err;
  assign stop_ok = rx_s2 & ~par_err;
`else
  assign stop_ok = rx_s2;
`endif

  assign valid_o   = (count != '0);
  assign data_o    = valid_o ? mem[rd_ptr] : 8'h00;
  assign full      = (count == CW'(FIFO_DEPTH));
  assign pop       = valid_o & ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_ok   = push_vld & (~full | pop);
  assign push_drop = push_vld & full & ~pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      rx_prev     <= 1'b1;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      push_vld    <= 1'b0;
      push_dat    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      char_cnt_o  <= '0;
`ifdef UART_RX_MON_PARITY_EN
      par_err     <= 1'b0;
`endif
    end else begin
      rx_s1    <= rx_i;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      push_vld <= 1'b0;

      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop);

      // Clear first so a same-cycle increment or flag set below wins.
      if (clear_i) begin
        frame_err_o <= 1'b0;
        overrun_o   <= 1'b0;
        char_cnt_o  <= '0;
      end
      if (push_ok)   char_cnt_o <= char_cnt_o + 16'd1;
      if (push_drop) overrun_o  <= 1'b1;

      if (!rx_en_i) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (rx_prev && !rx_s2) begin
              state   <= S_START;
              bit_cnt <= HALF_BIT;
            end
          end
          S_START: begin
            if (bit_cnt == '0) begin
              if (!rx_s2) begin
                state   <= S_DATA;
                bit_cnt <= FULL_BIT;
                bit_idx <= '0;
`ifdef UART_RX_MON_PARITY_EN
                par_err <= 1'b0;
`endif
              end else begin
                state <= S_IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt - 16'd1;
            end
          end
          S_DATA: begin
            if (bit_cnt == '0) begin
              shift   <= {rx_s2, shift[7:1]};
              bit_cnt <= FULL_BIT;
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) begin
`ifdef UART_RX_MON_PARITY_EN
                state <= S_PAR;
`else
                state <= S_STOP;
`endif
              end
            end else begin
              bit_cnt <= bit_cnt - 16'd1;
            end
          end
`ifdef UART_RX_MON_PARITY_EN
          S_PAR: begin
            if (bit_cnt == '0) begin
              // Even parity: data ones plus parity bit must be even.
              par_err <= (^shift) ^ rx_s2;
              bit_cnt <= FULL_BIT;
              state   <= S_STOP;
            end else begin
              bit_cnt <= bit_cnt - 16'd1;
            end
          end
`endif
          S_STOP: begin
            if (bit_cnt == '0) begin
              if (stop_ok) begin
                push_vld <= 1'b1;
                push_dat <= shift;
                state    <= S_IDLE;
              end else begin
                frame_err_o <= 1'b1;
                state       <= S_BREAK;
              end
            end else begin
              bit_cnt <= bit_cnt - 16'd1;
            end
          end
          S_BREAK: begin
            if (rx_s2) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench for uart_rx_monitor: framing, FIFO order/overrun, glitch, reset and enable abort.
module tb_uart_rx_monitor;

  localparam int BITC = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_i;
  logic        rx_en_i;
  logic        clear_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;
  logic        frame_err_o;
  logic        overrun_o;
  logic [15:0] char_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  uart_rx_monitor #(.BIT_CYCLES(BITC), .FIFO_DEPTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_i        (rx_i),
    .rx_en_i     (rx_en_i),
    .clear_i     (clear_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .char_cnt_o  (char_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start bit, 8 data bits LSB first, then ntail trailing bits (tail[0] first).
  task automatic send_bits(input logic [7:0] b, input logic [1:0] tail, input int ntail);
    @(negedge clk);
    rx_i = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (BITC) @(negedge clk);
    end
    for (int j = 0; j < ntail; j++) begin
      rx_i = tail[j];
      repeat (BITC) @(negedge clk);
    end
    rx_i = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
`ifdef UART_RX_MON_PARITY_EN
    send_bits(b, {stop_bit, ^b}, 2);
`else
    send_bits(b, {1'b1, stop_bit}, 1);
`endif
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    @(negedge clk);
    check({tag, "_valid"}, valid_o, 1'b1);
    check({tag, "_data"}, data_o, exp);
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
  endtask

  initial begin
    logic [7:0] b55;
    rst = 1'b1; rx_i = 1'b1; rx_en_i = 1'b1; clear_i = 1'b0; ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", valid_o, 1'b0);
    check("rst_data", data_o, 8'h00);
    check("rst_ferr", frame_err_o, 1'b0);
    check("rst_ovr", overrun_o, 1'b0);
    check("rst_cnt", char_cnt_o, 16'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single byte; push lands ~308 cycles after the start edge, send returns at 320.
    send_byte(8'h65, 1'b1);
    check("b65_valid_by_deadline", valid_o, 1'b1);
    check("b65_cnt", char_cnt_o, 16'd1);
    check("b65_ferr", frame_err_o, 1'b0);
    check("b65_ovr", overrun_o, 1'b0);
    pop_check("b65", 8'h65);
    check("b65_empty", valid_o, 1'b0);

    pulse_clear();
    check("clr_cnt", char_cnt_o, 16'd0);

    // Nine bytes into an 8-deep FIFO.
    for (int k = 0; k < 9; k++) begin
      send_byte(8'(k), 1'b1);
      repeat (4) @(negedge clk);
    end
    check("ovr_flag", overrun_o, 1'b1);
    check("ovr_cnt", char_cnt_o, 16'd8);
    for (int k = 0; k < 8; k++) pop_check("ovr_pop", 8'(k));
    @(negedge clk);
    check("ovr_empty", valid_o, 1'b0);

    pulse_clear();
    check("clr_ovr", overrun_o, 1'b0);
    check("clr_cnt2", char_cnt_o, 16'd0);

    // Framing error then recovery.
    send_byte(8'hA5, 1'b0);
    repeat (40) @(negedge clk);
    check("fe_flag", frame_err_o, 1'b1);
    check("fe_valid", valid_o, 1'b0);
    check("fe_cnt", char_cnt_o, 16'd0);
    send_byte(8'h3C, 1'b1);
    check("fe_next_cnt", char_cnt_o, 16'd1);
    pop_check("fe_next", 8'h3C);

    // Clear leaves FIFO contents alone.
    send_byte(8'hC3, 1'b1);
    pulse_clear();
    check("clr_ferr", frame_err_o, 1'b0);
    check("clr_cnt3", char_cnt_o, 16'd0);
    pop_check("clr_keep", 8'hC3);

    // Short glitch must not start a frame.
    @(negedge clk);
    rx_i = 1'b0;
    repeat (10) @(negedge clk);
    rx_i = 1'b1;
    repeat (400) @(negedge clk);
    check("gl_valid", valid_o, 1'b0);
    check("gl_ferr", frame_err_o, 1'b0);
    check("gl_cnt", char_cnt_o, 16'd0);

    // Reset in the middle of data bit 4 of 0x55.
    b55 = 8'h55;
    @(negedge clk);
    rx_i = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_i = b55[i];
      repeat (BITC) @(negedge clk);
    end
    rx_i = b55[4];
    repeat (BITC / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid_valid", valid_o, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rx_i = 1'b1;
    repeat (400) @(negedge clk);
    check("rstmid_novalid", valid_o, 1'b0);
    check("rstmid_ferr", frame_err_o, 1'b0);
    send_byte(8'h38, 1'b1);
    check("rstmid_cnt", char_cnt_o, 16'd1);
    pop_check("rstmid_38", 8'h38);
    @(negedge clk);
    check("rstmid_empty", valid_o, 1'b0);

    // Enable dropped mid-frame: line held low would otherwise end in a framing error.
    pulse_clear();
    @(negedge clk);
    rx_i = 1'b0;
    repeat (100) @(negedge clk);
    rx_en_i = 1'b0;
    repeat (300) @(negedge clk);
    rx_i = 1'b1;
    repeat (40) @(negedge clk);
    rx_en_i = 1'b1;
    repeat (40) @(negedge clk);
    check("en_ferr", frame_err_o, 1'b0);
    check("en_valid", valid_o, 1'b0);
    send_byte(8'h9A, 1'b1);
    pop_check("en_after", 8'h9A);

`ifdef UART_RX_MON_PARITY_EN
    pulse_clear();
    send_bits(8'h07, 2'b10, 2);
    repeat (40) @(negedge clk);
    check("par_bad_ferr", frame_err_o, 1'b1);
    check("par_bad_valid", valid_o, 1'b0);
    send_bits(8'h07, 2'b11, 2);
    check("par_ok_cnt", char_cnt_o, 16'd1);
    pop_check("par_ok", 8'h07);
`endif

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
